// File: rtl/clock_display_mux_pkg.sv
// rtl/clock_display_mux_pkg.sv - shared constants, digit codes and BCD helper for clock_display_mux
package clock_disp_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [2:0] digit_idx_t;

   localparam digit_idx_t LAST_IDX = 3'(NUM_DIGITS - 1);

   // Largest legal values of the incoming time fields
   localparam logic [5:0] MAX_MIN_SEC = 6'd59;
   localparam logic [5:0] MAX_HOURS   = 6'd23;

   // Non-numeric glyph codes fed to the segment decoder
   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd11;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Split a 0..59 value into {tens, ones} decimal digits
   function automatic logic [7:0] bcd_split(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

endpackage

// File: rtl/clock_display_mux_seg7_decode.sv
// rtl/clock_display_mux_seg7_decode.sv - digit/dash/blank code to active-high seven-segment pattern
module seg7_decode
   import clock_disp_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] pattern
);

   // Pure lookup; unused codes render blank
   always_comb begin
      pattern = SEG_BLANK;
      case (code)
         4'd0:      pattern = SEG_0;
         4'd1:      pattern = SEG_1;
         4'd2:      pattern = SEG_2;
         4'd3:      pattern = SEG_3;
         4'd4:      pattern = SEG_4;
         4'd5:      pattern = SEG_5;
         4'd6:      pattern = SEG_6;
         4'd7:      pattern = SEG_7;
         4'd8:      pattern = SEG_8;
         4'd9:      pattern = SEG_9;
         CODE_DASH: pattern = SEG_DASH;
         default:   pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/clock_display_mux.sv
// rtl/clock_display_mux.sv - six-digit multiplexed time display with frame snapshot; CLOCK_DISP_12H_EN selects 12-hour form
module clock_display_mux
   import clock_disp_pkg::*;
#(
   parameter int REFRESH_DIV      = 50000,
   parameter int SEG_ACTIVE_LOW   = 1,
   parameter int DIGIT_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] seconds,
   input  logic [5:0] minutes,
   input  logic [5:0] hours,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] digit_en
);

   localparam int              DIV_W    = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [6:0]      SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic            DP_INV   = (SEG_ACTIVE_LOW != 0);
   localparam logic [5:0]      EN_INV   = (DIGIT_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

   logic [DIV_W-1:0] div_q, div_d;
   digit_idx_t       idx_q, idx_d;
   logic [5:0]       snap_s_q, snap_s_d, snap_m_q, snap_m_d, snap_h_q, snap_h_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [5:0]       digit_en_q, digit_en_d;

   logic       advance, wrap;
   logic [5:0] src_s, src_m, src_h, h_disp;
   logic [7:0] s_bcd, m_bcd, h_bcd;
   logic       s_ok, m_ok, h_ok, pm;
   logic [3:0] h_tens, code;
   logic [6:0] pattern;

   // Scan timing, snapshot capture and field source selection
   always_comb begin
      advance  = (div_q == DIV_LAST);
      wrap     = (idx_q == LAST_IDX);
      div_d    = advance ? '0 : div_q + DIV_W'(1);
      idx_d    = idx_q;
      snap_s_d = snap_s_q;
      snap_m_d = snap_m_q;
      snap_h_d = snap_h_q;
      if (advance) begin
         idx_d = wrap ? '0 : idx_q + 3'd1;
         if (wrap) begin
            snap_s_d = seconds;
            snap_m_d = minutes;
            snap_h_d = hours;
         end
      end
      // Digit 0 is decoded on the wrap edge itself, so it must see the values being captured
      src_s = wrap ? seconds : snap_s_q;
      src_m = wrap ? minutes : snap_m_q;
      src_h = wrap ? hours   : snap_h_q;
   end

   // Range checks, hour mapping and per-digit glyph selection for the incoming index
   always_comb begin
      s_ok  = (src_s <= MAX_MIN_SEC);
      m_ok  = (src_m <= MAX_MIN_SEC);
      h_ok  = (src_h <= MAX_HOURS);
      s_bcd = bcd_split(src_s);
      m_bcd = bcd_split(src_m);
`ifdef CLOCK_DISP_12H_EN
      if (src_h == 6'd0)
         h_disp = 6'd12;
      else if (src_h > 6'd12)
         h_disp = src_h - 6'd12;
      else
         h_disp = src_h;
      h_bcd  = bcd_split(h_disp);
      h_tens = (h_disp < 6'd10) ? CODE_BLANK : h_bcd[7:4];
      pm     = h_ok && (src_h >= 6'd12);
`else
      h_disp = src_h;
      h_bcd  = bcd_split(h_disp);
      h_tens = h_bcd[7:4];
      pm     = 1'b0;
`endif
      code = CODE_BLANK;
      case (idx_d)
         3'd0:    code = h_ok ? h_tens     : CODE_DASH;
         3'd1:    code = h_ok ? h_bcd[3:0] : CODE_DASH;
         3'd2:    code = m_ok ? m_bcd[7:4] : CODE_DASH;
         3'd3:    code = m_ok ? m_bcd[3:0] : CODE_DASH;
         3'd4:    code = s_ok ? s_bcd[7:4] : CODE_DASH;
         3'd5:    code = s_ok ? s_bcd[3:0] : CODE_DASH;
         default: code = CODE_BLANK;
      endcase
   end

   seg7_decode u_dec (
      .code    (code),
      .pattern (pattern)
   );

   // Output register loads; pin polarity is applied only here
   always_comb begin
      seg_d      = seg_q;
      dp_d       = dp_q;
      digit_en_d = digit_en_q;
      if (advance) begin
         seg_d      = pattern ^ SEG_INV;
         dp_d       = ((idx_d == 3'd1) || (idx_d == 3'd3) || ((idx_d == LAST_IDX) && pm)) ^ DP_INV;
         digit_en_d = (6'b000001 << idx_d) ^ EN_INV;
      end
   end

   // State registers; reset blanks the pins immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q      <= '0;
         idx_q      <= LAST_IDX;
         snap_s_q   <= '0;
         snap_m_q   <= '0;
         snap_h_q   <= '0;
         seg_q      <= SEG_BLANK ^ SEG_INV;
         dp_q       <= DP_INV;
         digit_en_q <= EN_INV;
      end else begin
         div_q      <= div_d;
         idx_q      <= idx_d;
         snap_s_q   <= snap_s_d;
         snap_m_q   <= snap_m_d;
         snap_h_q   <= snap_h_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         digit_en_q <= digit_en_d;
      end
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign digit_en = digit_en_q;

endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Downstream display stage for `digital_clock`. Takes the binary `hours`/`minutes`/`seconds` fields and converts each to two decimal digits. It time-multiplexes the six digits onto one shared seven-segment bus with per-digit enables and drives the colon points. A snapshot is taken once per scan frame so a refresh never shows a torn time.

## Interface
- `REFRESH_DIV`, 50000: clk cycles each digit stays enabled; legal ≥2.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg` and `dp` at the pins.
- `DIGIT_ACTIVE_LOW`, 1: 1 inverts `digit_en` at the pins.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `seconds`  in  6  binary 0..59 from upstream counter.
- `minutes`  in  6  binary 0..59.
- `hours`  in  6  binary 0..23.
- `seg`  out  7  {g,f,e,d,c,b,a}; registered.
- `dp`  out  1  decimal point of enabled digit; registered.
- `digit_en`  out  6  one-hot digit enable; bit 0 = leftmost digit; registered.

## Operation
- Digit index 0..5 maps to hour tens, hour ones, minute tens, minute ones, second tens, second ones.
- Divider `div` counts 0..REFRESH_DIV-1 and wraps. On the edge where `div`==REFRESH_DIV-1:
  - the index advances (5→0 wraps);
  - `seg`, `dp` and `digit_en` load the decode of the new index.
- Snapshot: on the edge where the index goes 5→0, the three input fields are captured.
  - Digit 0 of that frame is decoded from the values being captured.
  - Digits 1..5 use the snapshot.
- BCD split: tens = v/10, ones = v%10, for v 0..59.
- Field out of range (seconds or minutes >59, hours >23): both digits of that field show `-`.
- Segment patterns before polarity, active-high: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, `-`=0x40, blank=0x00.
- `dp` is active on digits 1 and 3 (colons) and inactive elsewhere, unless overridden by Configuration.
- Polarity parameters invert only at the output registers' D inputs; internal logic is active-high.

## Timing
- Reset values, all async: `div`=0, index=5, snapshot=0, `seg`=blank, `dp` inactive, `digit_en` all inactive (all pin levels after polarity applied).
- First enabled digit: `digit_en[0]` goes active on the REFRESH_DIV-th rising edge after reset deasserts.
- Each digit is active for exactly REFRESH_DIV cycles. Frame = 6·REFRESH_DIV cycles.
- Exactly one `digit_en` bit is active at any time after the first advance. There is no overlap and no gap cycle.
- Input-to-display latency is up to 7·REFRESH_DIV cycles. Input changes mid-frame are invisible until the next 5→0 advance.
- Reset asserted mid-scan blanks all outputs in the same cycle, asynchronously. Release restarts the frame from the reset values.

## Configuration
- Macro `CLOCK_DISP_12H_EN`.
- **Defined:** hours are shown in 12-hour form.
  - Displayed hour: 0→12, 1..12 unchanged, 13..23→1..11.
  - Hour tens digit blank when the displayed hour is <10.
  - PM indicator: `dp` active on digit 5 when the snapshot hours is 12..23.
  - Out-of-range hours still show `-` `-` with PM off.
- **Undefined:** 24-hour form; hour tens shows `0` with no blanking; digit-5 `dp` always inactive.

## Structure
- Package `clock_disp_pkg`:
  - segment pattern constants (digits, dash, blank);
  - `NUM_DIGITS`=6 and the digit-index typedef (3 bits);
  - field range limits (59, 23).
- Sub-module `seg7_decode`: combinational 4-bit code (0..9, dash, blank) → 7-bit pattern. Instantiated once on the selected digit.
- Top holds divider, index, snapshot, BCD split, 12-hour mapping, and output registers.

## Test plan
All scenarios use REFRESH_DIV=4, SEG_ACTIVE_LOW=0, DIGIT_ACTIVE_LOW=0 unless noted.
- **Basic frame:** reset, inputs 12:34:56 → outputs blank for 3 edges; then `digit_en` 0x01 with `seg` 0x06, then 0x02/0x5B with `dp`=1, 0x04/0x4F, 0x08/0x66 with `dp`=1, 0x10/0x6D, 0x20/0x7D, each 4 cycles.
- **Snapshot hold:** change seconds 56→57 while digit 2 is active → digit 5 still shows 0x7D this frame; next frame shows 0x07.
- **Out of range:** seconds=60, minutes=0, hours=0 → digits 4 and 5 show 0x40; the rest show 0x3F.
- **12-hour mode (`CLOCK_DISP_12H_EN`):**
  - hours=0 → digits 0,1 = 0x06, 0x5B, PM `dp` off;
  - hours=13 → digit 0 blank 0x00, digit 1 0x06, `dp`=1 on digit 5.
- **Reset mid-scan:** assert reset while digit 3 is active → `seg`=0, `digit_en`=0, `dp`=0 before the next edge. After release, `digit_en[0]` is active on edge 4.
- **Polarity:** SEG_ACTIVE_LOW=1, DIGIT_ACTIVE_LOW=1, digit 0 showing `1` → `seg`=0x79, `digit_en`=0x3E; in reset `seg`=0x7F, `digit_en`=0x3F, `dp`=1.
